// File: rtl/instr_mem_loadable.sv
// ---------------------------------------------------------------------------
// instr_mem_loadable
//
// Byte-addressed, big-endian instruction memory for the fetch stage of a
// pipelined CPU. The program is streamed in after reset over a valid/ready
// byte interface. Once the last byte is accepted, the block switches to its
// run phase and serves word fetches with one cycle of registered latency.
//
// Fetches are checked before they return data:
//   - A misaligned fetch returns NOP_WORD and raises misaligned.
//   - A fetch that reaches past the loaded program returns NOP_WORD.
// The memory array is never cleared. A program length of zero is enough to
// keep stale contents from being fetched.
//
// Parameters
//   WORD_LEN  instruction width in bits (multiple of CELL_W)
//   CELL_W    memory cell width in bits
//   DEPTH     number of cells (power of 2, >= WORD_LEN/CELL_W)
//   NOP_WORD  word returned for out-of-program or misaligned fetches
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   load_valid   load byte present
//   load_byte    program byte, written at the next sequential cell
//   load_last    marks the final byte of the program
//   load_ready   block accepts a load byte this cycle
//   load_done    program loaded; fetch port live
//   prog_len     number of cells loaded
//   fetch_en     fetch request
//   fetch_addr   byte address (PC)
//   instr        fetched instruction
//   instr_valid  instr holds the result of the previous-cycle fetch
//   misaligned   previous fetch address was not word aligned
// ---------------------------------------------------------------------------
module instr_mem_loadable #(
    parameter int                  WORD_LEN = 32,
    parameter int                  CELL_W   = 8,
    parameter int                  DEPTH    = 1024,
    parameter logic [WORD_LEN-1:0] NOP_WORD = {WORD_LEN{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    input  logic [CELL_W-1:0]        load_byte,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     load_done,
    output logic [$clog2(DEPTH):0]   prog_len,
    input  logic                     fetch_en,
    input  logic [WORD_LEN-1:0]      fetch_addr,
    output logic [WORD_LEN-1:0]      instr,
    output logic                     instr_valid,
    output logic                     misaligned
);

    localparam int AW      = $clog2(DEPTH);
    localparam int N_CELLS = WORD_LEN / CELL_W;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Program storage and load-side state
    logic [CELL_W-1:0]   mem_r [DEPTH];
    state_t              state_r;
    logic [AW-1:0]       wptr_r;
    logic [AW:0]         prog_len_r;
    logic                load_ready_r;
    logic                load_done_r;

    // Fetch-side registered results
    logic [WORD_LEN-1:0] instr_r;
    logic                instr_valid_r;
    logic                misaligned_r;

    // Combinational helpers
    logic                accept_s;
    logic                last_s;
    logic [AW-1:0]       fetch_idx_s;
    logic [AW+1:0]       fetch_end_s;
    logic                in_range_s;
    logic                mis_s;
    logic [WORD_LEN-1:0] word_s;
    logic [WORD_LEN-1:0] next_instr_s;

    // True when the byte address does not fall on a word boundary.
    function automatic logic is_misaligned(input logic [WORD_LEN-1:0] addr);
        return (addr % WORD_LEN'(N_CELLS)) != {WORD_LEN{1'b0}};
    endfunction

    assign load_ready  = load_ready_r;
    assign load_done   = load_done_r;
    assign prog_len    = prog_len_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign misaligned  = misaligned_r;

    // Load handshake, and the end of the program.
    // The top cell ends the load even without load_last. Because of that,
    // extra bytes are never accepted and the write pointer never wraps
    // onto cells that hold program bytes.
    always_comb begin
        accept_s = load_valid & load_ready_r;
        last_s   = load_last | (wptr_r == AW'(DEPTH - 1));
    end

    // Memory write port. A byte offered in the same cycle as rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && accept_s) begin
            mem_r[wptr_r] <= load_byte;
        end
    end

    // Load/run FSM. It tracks the write pointer and the program length.
    // The ready/done flags are registered next to the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_LOAD;
            wptr_r       <= {AW{1'b0}};
            prog_len_r   <= {(AW+1){1'b0}};
            load_ready_r <= 1'b1;
            load_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        wptr_r     <= wptr_r + {{(AW-1){1'b0}}, 1'b1};
                        prog_len_r <= prog_len_r + {{AW{1'b0}}, 1'b1};
                        if (last_s) begin
                            state_r      <= ST_RUN;
                            load_ready_r <= 1'b0;
                            load_done_r  <= 1'b1;
                        end else begin
                            load_ready_r <= 1'b1;
                            load_done_r  <= 1'b0;
                        end
                    end else begin
                        load_ready_r <= 1'b1;
                        load_done_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Only rst leaves RUN.
                    load_ready_r <= 1'b0;
                    load_done_r  <= 1'b1;
                end
                default: begin
                    state_r      <= ST_LOAD;
                    wptr_r       <= {AW{1'b0}};
                    prog_len_r   <= {(AW+1){1'b0}};
                    load_ready_r <= 1'b1;
                    load_done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Fetch decode: wrap the address into the array, do the alignment and
    // range checks, and assemble the word with the first byte as the MSB.
    always_comb begin
        fetch_idx_s = fetch_addr[AW-1:0];
        mis_s       = is_misaligned(fetch_addr);
        // Use a wide sum so that a + N cannot overflow before the compare.
        fetch_end_s = (AW+2)'(fetch_idx_s) + (AW+2)'(N_CELLS);
        in_range_s  = (fetch_end_s <= (AW+2)'(prog_len_r));
        word_s      = {WORD_LEN{1'b0}};
        for (int i = 0; i < N_CELLS; i++) begin
            word_s[WORD_LEN-1-i*CELL_W -: CELL_W] = mem_r[fetch_idx_s + AW'(i)];
        end
        if (mis_s) begin
            next_instr_s = NOP_WORD;
        end else if (in_range_s) begin
            next_instr_s = word_s;
        end else begin
            next_instr_s = NOP_WORD;
        end
    end

    // Registered fetch result. An idle cycle holds instr and misaligned
    // and only drops instr_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r       <= NOP_WORD;
            instr_valid_r <= 1'b0;
            misaligned_r  <= 1'b0;
        end else if ((state_r == ST_RUN) && fetch_en) begin
            instr_r       <= next_instr_s;
            instr_valid_r <= 1'b1;
            misaligned_r  <= mis_s;
        end else begin
            instr_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loadable
//
// Directed testbench for instr_mem_loadable. It uses two instances:
//   dut    default configuration (DEPTH=1024)
//   dut_s  DEPTH=16, used for the implicit-last and address-wrap case
// Inputs change 1 time unit after the rising edge. Outputs are sampled at
// that same point, so they reflect the registers updated by that edge.
// ---------------------------------------------------------------------------
module tb_instr_mem_loadable;

    logic        clk = 1'b0;
    int          total = 0;
    int          bad   = 0;

    // Default instance signals
    logic        rst, load_valid, load_last, fetch_en;
    logic [7:0]  load_byte;
    logic [31:0] fetch_addr;
    logic        load_ready, load_done, instr_valid, misaligned;
    logic [10:0] prog_len;
    logic [31:0] instr;

    // DEPTH=16 instance signals
    logic        s_rst, s_load_valid, s_load_last, s_fetch_en;
    logic [7:0]  s_load_byte;
    logic [31:0] s_fetch_addr;
    logic        s_load_ready, s_load_done, s_instr_valid, s_misaligned;
    logic [4:0]  s_prog_len;
    logic [31:0] s_instr;

    always #5 clk = ~clk;

    instr_mem_loadable dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_byte(load_byte),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .prog_len(prog_len), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .instr(instr), .instr_valid(instr_valid), .misaligned(misaligned)
    );

    instr_mem_loadable #(.DEPTH(16)) dut_s (
        .clk(clk), .rst(s_rst), .load_valid(s_load_valid), .load_byte(s_load_byte),
        .load_last(s_load_last), .load_ready(s_load_ready), .load_done(s_load_done),
        .prog_len(s_prog_len), .fetch_en(s_fetch_en), .fetch_addr(s_fetch_addr),
        .instr(s_instr), .instr_valid(s_instr_valid), .misaligned(s_misaligned)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; fetch_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Offer one byte for one cycle (LOAD always has load_ready=1).
    task automatic send_byte(input logic [7:0] b, input logic last);
        load_valid = 1'b1; load_byte = b; load_last = last;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        fetch_en = 1'b1; fetch_addr = addr;
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h exp=1", load_ready); end
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h exp=0", load_done); end
        total++; if (prog_len !== 11'd0) begin bad++; $display("FAIL reset_len got=%0d exp=0", prog_len); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_ivalid got=%0h exp=0", instr_valid); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%0h exp=0", misaligned); end
        // A fetch during LOAD is ignored.
        fetch(32'h0);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL load_fetch_ignored got=%0h exp=0", instr_valid); end
    endtask

    task automatic test_basic_load();
        do_reset();
        send_byte(8'h80, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b1);
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0h exp=1", load_done); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL basic_ready got=%0h exp=0", load_ready); end
        total++; if (prog_len !== 11'd4) begin bad++; $display("FAIL basic_len got=%0d exp=4", prog_len); end
        fetch(32'h0);
        total++; if (instr !== 32'h8020_0001) begin bad++; $display("FAIL basic_instr got=%h exp=80200001", instr); end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL basic_ivalid got=%0h exp=1", instr_valid); end
        // Idle cycle: instr holds, valid drops.
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL idle_ivalid got=%0h exp=0", instr_valid); end
        total++; if (instr !== 32'h8020_0001) begin bad++; $display("FAIL idle_hold got=%h exp=80200001", instr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h10 + 8'(i), (i == 7));
            tick(); // gap cycle with load_valid low
        end
        total++; if (prog_len !== 11'd8) begin bad++; $display("FAIL b2b_len got=%0d exp=8", prog_len); end
        fetch_en = 1'b1; fetch_addr = 32'h4;
        tick();
        total++; if (instr !== 32'h1415_1617 || instr_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h/%0h exp=14151617/1", instr, instr_valid); end
        fetch_addr = 32'h0;
        tick();
        fetch_en = 1'b0;
        total++; if (instr !== 32'h1011_1213 || instr_valid !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%0h exp=10111213/1", instr, instr_valid); end
    endtask

    task automatic test_partial_and_misaligned();
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), (i == 5));
        total++; if (prog_len !== 11'd6) begin bad++; $display("FAIL part_len got=%0d exp=6", prog_len); end
        fetch(32'h0);
        total++; if (instr !== 32'hA0A1_A2A3) begin bad++; $display("FAIL part_w0 got=%h exp=a0a1a2a3", instr); end
        fetch(32'h4);
        total++; if (instr !== 32'h0 || instr_valid !== 1'b1 || misaligned !== 1'b0) begin bad++; $display("FAIL part_partial got=%h/%0h/%0h exp=0/1/0", instr, instr_valid, misaligned); end
        fetch(32'h0);
        fetch(32'h8);
        total++; if (instr !== 32'h0 || instr_valid !== 1'b1) begin bad++; $display("FAIL part_past got=%h/%0h exp=0/1", instr, instr_valid); end
        fetch(32'h0);
        fetch(32'h2);
        total++; if (instr !== 32'h0 || misaligned !== 1'b1 || instr_valid !== 1'b1) begin bad++; $display("FAIL mis_flag got=%h/%0h/%0h exp=0/1/1", instr, misaligned, instr_valid); end
        tick();
        total++; if (misaligned !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL mis_hold got=%0h/%0h exp=1/0", misaligned, instr_valid); end
        fetch(32'h0);
        total++; if (misaligned !== 1'b0 || instr !== 32'hA0A1_A2A3) begin bad++; $display("FAIL mis_clear got=%0h/%h exp=0/a0a1a2a3", misaligned, instr); end
    endtask

    task automatic test_depth_wrap();
        s_rst = 1'b1; s_load_valid = 1'b0; s_load_last = 1'b0; s_fetch_en = 1'b0;
        s_load_byte = 8'h0; s_fetch_addr = 32'h0;
        tick();
        s_rst = 1'b0;
        s_load_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_load_byte = 8'h40 + 8'(i);
            tick();
            if (i == 14) begin
                total++; if (s_load_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready15 got=%0h exp=1", s_load_ready); end
            end
            if (i == 15) begin
                total++; if (s_load_ready !== 1'b0 || s_load_done !== 1'b1) begin bad++; $display("FAIL wrap_full got=%0h/%0h exp=0/1", s_load_ready, s_load_done); end
            end
        end
        s_load_valid = 1'b0;
        total++; if (s_prog_len !== 5'd16) begin bad++; $display("FAIL wrap_len got=%0d exp=16", s_prog_len); end
        s_fetch_en = 1'b1; s_fetch_addr = 32'h10;
        tick();
        total++; if (s_instr !== 32'h4041_4243 || s_instr_valid !== 1'b1) begin bad++; $display("FAIL wrap_fetch got=%h/%0h exp=40414243/1", s_instr, s_instr_valid); end
        s_fetch_addr = 32'hC;
        tick();
        s_fetch_en = 1'b0;
        total++; if (s_instr !== 32'h4C4D_4E4F) begin bad++; $display("FAIL wrap_top got=%h exp=4c4d4e4f", s_instr); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        send_byte(8'hC0, 1'b0);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        // Byte offered together with rst must be dropped.
        rst = 1'b1; load_valid = 1'b1; load_byte = 8'hEE;
        tick();
        rst = 1'b0; load_valid = 1'b0;
        total++; if (prog_len !== 11'd0 || load_ready !== 1'b1 || load_done !== 1'b0) begin bad++; $display("FAIL midrst_state got=%0d/%0h/%0h exp=0/1/0", prog_len, load_ready, load_done); end
        tick();
        total++; if (prog_len !== 11'd0) begin bad++; $display("FAIL midrst_drop got=%0d exp=0", prog_len); end
        send_byte(8'hD0, 1'b0);
        send_byte(8'hD1, 1'b0);
        send_byte(8'hD2, 1'b0);
        send_byte(8'hD3, 1'b1);
        fetch(32'h0);
        total++; if (instr !== 32'hD0D1_D2D3) begin bad++; $display("FAIL midrst_reload got=%h exp=d0d1d2d3", instr); end
        // Reset during RUN returns to the reset state.
        do_reset();
        total++; if (instr !== 32'h0 || load_done !== 1'b0 || prog_len !== 11'd0) begin bad++; $display("FAIL runrst got=%h/%0h/%0d exp=0/0/0", instr, load_done, prog_len); end
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_byte = 8'h0;
        fetch_en = 1'b0; fetch_addr = 32'h0;
        s_rst = 1'b1; s_load_valid = 1'b0; s_load_last = 1'b0; s_load_byte = 8'h0;
        s_fetch_en = 1'b0; s_fetch_addr = 32'h0;
        test_reset();
        test_basic_load();
        test_back_to_back();
        test_partial_and_misaligned();
        test_depth_wrap();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
